sram_loader: RTL and testbench
==============================

SRAM_LOADER -- requirements
Module: sram_loader

Interface
REQ-001 SHALL have parameters: ADDRESS_WIDTH, default 22, SRAM address width; DATA_WIDTH, default 32, FIFO word width; FPGA_DATA_WIDTH, default 16, SRAM data width; SETUP_CYCLES, default 1, ADV/CS setup length; WRITE_CYCLES, default 3, WE-low length; HOLD_CYCLES, default 1, strobes-high length.
REQ-002 SHALL have one clock and a synchronous, active-high reset, as the ports below.
REQ-003 sram_loader_clk_i  in  1  master clock; all logic on rising edge.
REQ-004 sram_loader_rst_i  in  1  synchronous active-high reset.
REQ-005 load_en_i  in  1  1: loader owns SRAM; 0: microprocessor passthrough.
REQ-006 store_en_i  in  1  1: write fetched words to SRAM; 0: fetch and discard.
REQ-007 addr_load_i  in  1  load base_address_i, clear word count (IDLE only).
REQ-008 base_address_i  in  ADDRESS_WIDTH  start address.
REQ-009 fifo_datain_i  in  DATA_WIDTH  FIFO read data, valid the cycle after read_fifo_o.
REQ-010 fifo_empty_i  in  1  FIFO empty flag.
REQ-011 read_fifo_o  out  1  one-cycle FIFO pop strobe.
REQ-012 micro_sram_address_i  in  ADDRESS_WIDTH, micro_sram_datain_i  in  FPGA_DATA_WIDTH, micro_sram_control_i  in  6  microprocessor SRAM bus; control bits [0]cs [1]we [2]oe [4:3]lb_ub [5]adv.
REQ-013 sram_address_o  out  ADDRESS_WIDTH; sram_datain_o  out  FPGA_DATA_WIDTH; sram_cs_o, sram_we_o, sram_oe_o, sram_adv_o  out  1 each, active low; sram_lb_ub_o  out  2, active low; sram_wait_o  out  1, active low.
REQ-014 busy_o  out  1  loader FSM not in IDLE.
REQ-015 words_written_o  out  ADDRESS_WIDTH  FIFO words stored since last addr_load_i.

Function
REQ-016 BEATS = DATA_WIDTH/FPGA_DATA_WIDTH SHALL be an integer >= 1; the three cycle parameters SHALL each be >= 1.
REQ-017 SRAM outputs SHALL come from micro inputs when load_en_i=0 and busy_o=0; otherwise from the loader.
REQ-018 FSM states: IDLE, FETCH, LATCH, SETUP, WRITE, HOLD, NEXT.
REQ-019 IDLE: addr_load_i=1 -> address<=base_address_i, words_written<=0 (priority over start); else load_en_i=1 and fifo_empty_i=0 -> FETCH.
REQ-020 FETCH: read_fifo_o=1 for exactly one cycle -> LATCH.
REQ-021 LATCH: capture fifo_datain_i, beat<=0; store_en_i=1 -> SETUP, else -> IDLE with address and count unchanged.
REQ-022 SETUP (SETUP_CYCLES): adv=0, cs=0, we=1, lb_ub=11, address and beat data driven -> WRITE.
REQ-023 WRITE (WRITE_CYCLES): adv=1, cs=0, we=0, lb_ub=00, wait=0 -> HOLD.
REQ-024 HOLD (HOLD_CYCLES): cs=1, we=1, lb_ub=11, wait=1, data held; then address+1; last beat -> NEXT, else beat+1 -> SETUP.
REQ-025 NEXT: words_written+1 -> IDLE.
REQ-026 Beat order most-significant slice first; beat k drives fifo word bits [DATA_WIDTH-1-k*FPGA_DATA_WIDTH -: FPGA_DATA_WIDTH].
REQ-027 Address and words_written SHALL wrap modulo 2^ADDRESS_WIDTH with no flag.
REQ-028 Loader oe SHALL be constant 1; idle loader outputs: strobes 1, lb_ub 11, data 0.
REQ-029 load_en_i or store_en_i deasserted after LATCH SHALL not abort; the word completes all beats, then IDLE.
REQ-030 Per stored word latency SHALL be 3 + BEATS*(SETUP_CYCLES+WRITE_CYCLES+HOLD_CYCLES) cycles (13 at defaults).

Reset
REQ-031 Reset SHALL force IDLE, address 0, words_written 0, beat 0, read_fifo_o 0, busy_o 0, loader strobes inactive, sram_wait_o 1, data 0, overriding any in-progress write on the next edge.
REQ-032 During reset, SRAM outputs SHALL follow REQ-017 with busy_o=0.

Verification
REQ-033 Defaults, addr_load_i with base 0x000010, FIFO word 0xDEADBEEF, store_en_i=1 -> one read pulse; 0xDEAD written at 0x000010, 0xBEEF at 0x000011, WE low 3 cycles per beat; words_written=1; busy 13 cycles.
REQ-034 fifo_empty_i=1 with load_en_i=1 -> read_fifo_o stays 0, busy_o 0, no strobes.
REQ-035 store_en_i=0, three FIFO words -> three read pulses, 3 cycles apart; cs stays 1; address and words_written unchanged.
REQ-036 Base 0x3FFFFF, one word -> beats at 0x3FFFFF and 0x000000; final address 0x000001.
REQ-037 load_en_i dropped in beat 0 WRITE -> both beats complete, then outputs equal micro inputs (control 6'b101010 -> cs=0, we=1, oe=0, lb_ub=01, adv=1).
REQ-038 Reset asserted mid-WRITE -> next cycle cs=1, we=1, busy_o=0, address 0, words_written 0.

Source files
------------

// File: rtl/sram_loader.sv
// Streams FIFO words into an asynchronous SRAM as BEATS half-words, most
// significant slice first; a microprocessor owns the bus when the loader is idle.
module sram_loader #(
  parameter int ADDRESS_WIDTH   = 22,
  parameter int DATA_WIDTH      = 32,
  parameter int FPGA_DATA_WIDTH = 16,
  parameter int SETUP_CYCLES    = 1,
  parameter int WRITE_CYCLES    = 3,
  parameter int HOLD_CYCLES     = 1
) (
  input  logic                       sram_loader_clk_i,
  input  logic                       sram_loader_rst_i,
  input  logic                       load_en_i,
  input  logic                       store_en_i,
  input  logic                       addr_load_i,
  input  logic [ADDRESS_WIDTH-1:0]   base_address_i,
  input  logic [DATA_WIDTH-1:0]      fifo_datain_i,
  input  logic                       fifo_empty_i,
  output logic                       read_fifo_o,
  input  logic [ADDRESS_WIDTH-1:0]   micro_sram_address_i,
  input  logic [FPGA_DATA_WIDTH-1:0] micro_sram_datain_i,
  input  logic [5:0]                 micro_sram_control_i,
  output logic [ADDRESS_WIDTH-1:0]   sram_address_o,
  output logic [FPGA_DATA_WIDTH-1:0] sram_datain_o,
  output logic                       sram_cs_o,
  output logic                       sram_we_o,
  output logic                       sram_oe_o,
  output logic                       sram_adv_o,
  output logic [1:0]                 sram_lb_ub_o,
  output logic                       sram_wait_o,
  output logic                       busy_o,
  output logic [ADDRESS_WIDTH-1:0]   words_written_o
);

  localparam int BEATS  = DATA_WIDTH / FPGA_DATA_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int MAX_PHASE = (SETUP_CYCLES > WRITE_CYCLES) ?
                             ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES) :
                             ((WRITE_CYCLES > HOLD_CYCLES) ? WRITE_CYCLES : HOLD_CYCLES);
  localparam int CNT_W = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;

  localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  WRITE_LAST = CNT_W'(WRITE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BEATS - 1);

  generate
    if (BEATS < 1 || (DATA_WIDTH % FPGA_DATA_WIDTH) != 0 ||
        SETUP_CYCLES < 1 || WRITE_CYCLES < 1 || HOLD_CYCLES < 1) begin : gBadParams
      $error("sram_loader: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, SETUP, WRITE, HOLD, NEXT
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0] wordsWritten_q, wordsWritten_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [CNT_W-1:0]         phaseCnt_q, phaseCnt_d;
  logic [DATA_WIDTH-1:0]    word_q, word_d;

  always_ff @(posedge sram_loader_clk_i) begin
    if (sram_loader_rst_i) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      wordsWritten_q <= '0;
      beat_q         <= '0;
      phaseCnt_q     <= '0;
      word_q         <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wordsWritten_q <= wordsWritten_d;
      beat_q         <= beat_d;
      phaseCnt_q     <= phaseCnt_d;
      word_q         <= word_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wordsWritten_d = wordsWritten_q;
    beat_d         = beat_q;
    phaseCnt_d     = phaseCnt_q;
    word_d         = word_q;
    case (state_q)
      IDLE: begin
        if (addr_load_i) begin
          addr_d         = base_address_i;
          wordsWritten_d = '0;
        end else if (load_en_i && !fifo_empty_i) begin
          state_d = FETCH;
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        word_d     = fifo_datain_i;
        beat_d     = '0;
        phaseCnt_d = '0;
        state_d    = store_en_i ? SETUP : IDLE;
      end
      SETUP: begin
        if (phaseCnt_q == SETUP_LAST) begin
          phaseCnt_d = '0;
          state_d    = WRITE;
        end else begin
          phaseCnt_d = phaseCnt_q + 1'b1;
        end
      end
      WRITE: begin
        if (phaseCnt_q == WRITE_LAST) begin
          phaseCnt_d = '0;
          state_d    = HOLD;
        end else begin
          phaseCnt_d = phaseCnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (phaseCnt_q == HOLD_LAST) begin
          phaseCnt_d = '0;
          addr_d     = addr_q + 1'b1;
          if (beat_q == BEAT_LAST) begin
            state_d = NEXT;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = SETUP;
          end
        end else begin
          phaseCnt_d = phaseCnt_q + 1'b1;
        end
      end
      NEXT: begin
        wordsWritten_d = wordsWritten_q + 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shifting the current beat to the top keeps slice selection free of
  // variable part-select arithmetic.
  logic [31:0]                shiftAmt;
  logic [DATA_WIDTH-1:0]      wordShifted;
  logic [FPGA_DATA_WIDTH-1:0] beatData;

  assign shiftAmt    = 32'(beat_q) * 32'(FPGA_DATA_WIDTH);
  assign wordShifted = word_q << shiftAmt;
  assign beatData    = wordShifted[DATA_WIDTH-1 -: FPGA_DATA_WIDTH];

  logic                       ldCs, ldWe, ldAdv, ldWait;
  logic [1:0]                 ldLbUb;
  logic [FPGA_DATA_WIDTH-1:0] ldData;

  always_comb begin
    ldCs   = 1'b1;
    ldWe   = 1'b1;
    ldAdv  = 1'b1;
    ldWait = 1'b1;
    ldLbUb = 2'b11;
    ldData = '0;
    case (state_q)
      SETUP: begin
        ldAdv  = 1'b0;
        ldCs   = 1'b0;
        ldData = beatData;
      end
      WRITE: begin
        ldCs   = 1'b0;
        ldWe   = 1'b0;
        ldLbUb = 2'b00;
        ldWait = 1'b0;
        ldData = beatData;
      end
      HOLD:    ldData = beatData;
      default: ;
    endcase
  end

  assign busy_o          = (state_q != IDLE);
  assign read_fifo_o     = (state_q == FETCH);
  assign words_written_o = wordsWritten_q;

  // The micro keeps the bus only while the loader is neither enabled nor mid-word.
  always_comb begin
    if (!load_en_i && !busy_o) begin
      sram_address_o = micro_sram_address_i;
      sram_datain_o  = micro_sram_datain_i;
      sram_cs_o      = micro_sram_control_i[0];
      sram_we_o      = micro_sram_control_i[1];
      sram_oe_o      = micro_sram_control_i[2];
      sram_lb_ub_o   = micro_sram_control_i[4:3];
      sram_adv_o     = micro_sram_control_i[5];
      sram_wait_o    = 1'b1;
    end else begin
      sram_address_o = addr_q;
      sram_datain_o  = ldData;
      sram_cs_o      = ldCs;
      sram_we_o      = ldWe;
      sram_oe_o      = 1'b1;
      sram_lb_ub_o   = ldLbUb;
      sram_adv_o     = ldAdv;
      sram_wait_o    = ldWait;
    end
  end

endmodule

// File: tb/tb_sram_loader.sv
// Scoreboard bench for sram_loader: a FIFO model feeds words, expected SRAM
// writes and busy lengths are queued at stimulus time and popped by a monitor.
module tb_sram_loader;

  localparam int AW         = 22;
  localparam int DW         = 32;
  localparam int FW         = 16;
  localparam int BEATS      = DW / FW;
  localparam int WE_LOW     = 3;
  localparam int STORE_BUSY = 3 + BEATS * (1 + 3 + 1);
  localparam int SKIP_BUSY  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_en_i = 1'b0;
  logic          store_en_i = 1'b0;
  logic          addr_load_i = 1'b0;
  logic [AW-1:0] base_address_i = '0;
  logic [DW-1:0] fifo_datain_i = '0;
  logic          fifo_empty_i = 1'b1;
  logic          read_fifo_o;
  logic [AW-1:0] micro_sram_address_i = '0;
  logic [FW-1:0] micro_sram_datain_i = '0;
  logic [5:0]    micro_sram_control_i = 6'b111111;
  logic [AW-1:0] sram_address_o;
  logic [FW-1:0] sram_datain_o;
  logic          sram_cs_o, sram_we_o, sram_oe_o, sram_adv_o, sram_wait_o;
  logic [1:0]    sram_lb_ub_o;
  logic          busy_o;
  logic [AW-1:0] words_written_o;

  sram_loader dut (
    .sram_loader_clk_i    (clk),
    .sram_loader_rst_i    (rst),
    .load_en_i            (load_en_i),
    .store_en_i           (store_en_i),
    .addr_load_i          (addr_load_i),
    .base_address_i       (base_address_i),
    .fifo_datain_i        (fifo_datain_i),
    .fifo_empty_i         (fifo_empty_i),
    .read_fifo_o          (read_fifo_o),
    .micro_sram_address_i (micro_sram_address_i),
    .micro_sram_datain_i  (micro_sram_datain_i),
    .micro_sram_control_i (micro_sram_control_i),
    .sram_address_o       (sram_address_o),
    .sram_datain_o        (sram_datain_o),
    .sram_cs_o            (sram_cs_o),
    .sram_we_o            (sram_we_o),
    .sram_oe_o            (sram_oe_o),
    .sram_adv_o           (sram_adv_o),
    .sram_lb_ub_o         (sram_lb_ub_o),
    .sram_wait_o          (sram_wait_o),
    .busy_o               (busy_o),
    .words_written_o      (words_written_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [FW-1:0] data;
  } wr_t;

  wr_t           writeQ[$];
  int            busyQ[$];
  logic [DW-1:0] fifoQ[$];
  int            readCycles[$];

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int readCount = 0;
  int busyCycles = 0;
  int csLowCycles = 0;
  int busyRun = 0;
  int weRun = 0;
  logic prevWe = 1'b1;
  logic [AW-1:0] modelAddr = '0;
  logic [AW-1:0] modelCount = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // FIFO model: a pop strobe seen in one cycle presents data for the next.
  always @(negedge clk) begin
    if (!rst && read_fifo_o) begin
      if (fifoQ.size() > 0) fifo_datain_i = fifoQ.pop_front();
      else checkOutput("fifo underflow", 64'd1, 64'd0);
      fifo_empty_i = (fifoQ.size() == 0);
    end
  end

  // Monitor: pops expected writes on each loader WE fall, busy lengths on busy fall.
  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      busyRun = 0;
      weRun   = 0;
      prevWe  = 1'b1;
    end else begin
      if (read_fifo_o) begin
        readCount++;
        readCycles.push_back(cycle);
      end
      if (busy_o) begin
        busyCycles++;
        busyRun++;
      end else if (busyRun > 0) begin
        if (busyQ.size() == 0) checkOutput("unexpected busy run", 64'(busyRun), 64'd0);
        else checkOutput("busy length", 64'(busyRun), 64'(busyQ.pop_front()));
        busyRun = 0;
      end
      if (busy_o && !sram_cs_o) csLowCycles++;
      if (busy_o && !sram_we_o && prevWe) begin
        if (writeQ.size() == 0) begin
          checkOutput("unexpected write", 64'd1, 64'd0);
        end else begin
          wr_t e;
          e = writeQ.pop_front();
          checkOutput("write addr", 64'(sram_address_o), 64'(e.addr));
          checkOutput("write data", 64'(sram_datain_o), 64'(e.data));
          checkOutput("write strobes cs/lbub/adv/oe/wait",
                      64'({sram_cs_o, sram_lb_ub_o, sram_adv_o, sram_oe_o, sram_wait_o}),
                      64'(6'b0_00_1_1_0));
        end
      end
      if (busy_o && !sram_we_o) begin
        weRun++;
      end else if (weRun > 0) begin
        checkOutput("we low cycles", 64'(weRun), 64'(WE_LOW));
        weRun = 0;
      end
      prevWe = busy_o ? sram_we_o : 1'b1;
    end
  end

  task automatic applyStimulus(input logic [DW-1:0] word, input logic store);
    logic [DW-1:0] w;
    w = word;
    store_en_i = store;
    fifoQ.push_back(w);
    fifo_empty_i = 1'b0;
    if (store) begin
      for (int k = 0; k < BEATS; k++) begin
        wr_t e;
        e.addr = modelAddr;
        e.data = w[DW-1-k*FW -: FW];
        writeQ.push_back(e);
        modelAddr = modelAddr + 1'b1;
      end
      modelCount = modelCount + 1'b1;
      busyQ.push_back(STORE_BUSY);
    end else begin
      busyQ.push_back(SKIP_BUSY);
    end
  endtask

  task automatic loadBase(input logic [AW-1:0] base);
    @(posedge clk); #1;
    addr_load_i    = 1'b1;
    base_address_i = base;
    @(posedge clk); #1;
    addr_load_i = 1'b0;
    modelAddr   = base;
    modelCount  = '0;
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(fifoQ.size() == 0 && !busy_o) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) checkOutput({name, " timeout"}, 64'd1, 64'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic endCheck(input string name);
    checkOutput({name, " pending writes"}, 64'(writeQ.size()), 64'd0);
    checkOutput({name, " pending busy"}, 64'(busyQ.size()), 64'd0);
    checkOutput({name, " final address"}, 64'(sram_address_o), 64'(modelAddr));
    checkOutput({name, " words written"}, 64'(words_written_o), 64'(modelCount));
  endtask

  task automatic waitWeLow(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(busy_o && !sram_we_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput({name, " wait for WE"}, 64'd1, 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int r0, b0, c0;
    logic [AW-1:0] base;
    logic [AW-1:0] mAddr;
    logic [FW-1:0] mData;
    int n;
    logic st;

    // Reset with load_en low: bus follows the micro.
    micro_sram_address_i = 22'h2ABCDE;
    micro_sram_datain_i  = 16'h1234;
    micro_sram_control_i = 6'b101010;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", 64'(busy_o), 64'd0);
    checkOutput("reset read", 64'(read_fifo_o), 64'd0);
    checkOutput("reset words", 64'(words_written_o), 64'd0);
    checkOutput("reset micro address", 64'(sram_address_o), 64'h2ABCDE);
    checkOutput("reset micro data", 64'(sram_datain_o), 64'h1234);
    checkOutput("reset micro ctl", 64'({sram_adv_o, sram_lb_ub_o, sram_oe_o, sram_we_o, sram_cs_o}), 64'(6'b101010));
    load_en_i = 1'b1;
    #1;
    checkOutput("reset loader address", 64'(sram_address_o), 64'd0);
    checkOutput("reset loader data", 64'(sram_datain_o), 64'd0);
    checkOutput("reset loader ctl", 64'({sram_adv_o, sram_lb_ub_o, sram_oe_o, sram_we_o, sram_cs_o, sram_wait_o}), 64'(7'b1111111));
    micro_sram_control_i = 6'b111111;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single word 0xDEADBEEF from base 0x10.
    loadBase(22'h000010);
    applyStimulus(32'hDEADBEEF, 1'b1);
    waitDone("deadbeef");
    endCheck("deadbeef");

    // Empty FIFO: nothing happens.
    r0 = readCount; b0 = busyCycles; c0 = csLowCycles;
    repeat (20) @(negedge clk);
    checkOutput("empty reads", 64'(readCount - r0), 64'd0);
    checkOutput("empty busy", 64'(busyCycles - b0), 64'd0);
    checkOutput("empty cs", 64'(csLowCycles - c0), 64'd0);

    // Discard three words.
    readCycles.delete();
    c0 = csLowCycles;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) applyStimulus($urandom, 1'b0);
    waitDone("discard");
    endCheck("discard");
    checkOutput("discard reads", 64'(readCycles.size()), 64'd3);
    if (readCycles.size() == 3) begin
      checkOutput("discard gap 1", 64'(readCycles[1] - readCycles[0]), 64'd3);
      checkOutput("discard gap 2", 64'(readCycles[2] - readCycles[1]), 64'd3);
    end
    checkOutput("discard cs", 64'(csLowCycles - c0), 64'd0);

    // Address wrap at the top of the SRAM.
    loadBase(22'h3FFFFF);
    applyStimulus(32'hCAFEF00D, 1'b1);
    waitDone("wrap");
    endCheck("wrap");
    checkOutput("wrap address value", 64'(sram_address_o), 64'h000001);

    // Randomized batches.
    for (int it = 0; it < 8; it++) begin
      base = (it % 2 == 0) ? AW'($urandom) : AW'(22'h3FFFFF - AW'($urandom_range(0, 4)));
      loadBase(base);
      n  = $urandom_range(1, 4);
      st = 1'($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) applyStimulus($urandom, st);
      waitDone("random");
      endCheck("random");
    end

    // Drop load_en during the first beat's WRITE: the word still completes.
    loadBase(22'h000100);
    mAddr = AW'($urandom);
    mData = FW'($urandom);
    micro_sram_address_i = mAddr;
    micro_sram_datain_i  = mData;
    micro_sram_control_i = 6'b101010;
    @(posedge clk); #1;
    applyStimulus(32'h89ABCDEF, 1'b1);
    waitWeLow("drop");
    load_en_i = 1'b0;
    waitDone("drop");
    checkOutput("drop pending writes", 64'(writeQ.size()), 64'd0);
    checkOutput("drop words", 64'(words_written_o), 64'(modelCount));
    checkOutput("drop micro address", 64'(sram_address_o), 64'(mAddr));
    checkOutput("drop micro data", 64'(sram_datain_o), 64'(mData));
    checkOutput("drop micro cs", 64'(sram_cs_o), 64'd0);
    checkOutput("drop micro we", 64'(sram_we_o), 64'd1);
    checkOutput("drop micro oe", 64'(sram_oe_o), 64'd0);
    checkOutput("drop micro lbub", 64'(sram_lb_ub_o), 64'd1);
    checkOutput("drop micro adv", 64'(sram_adv_o), 64'd1);
    micro_sram_control_i = 6'b111111;
    load_en_i = 1'b1;

    // Reset in the middle of a WRITE.
    loadBase(22'h001234);
    @(posedge clk); #1;
    applyStimulus(32'h55AA33CC, 1'b1);
    waitWeLow("reset");
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midreset cs", 64'(sram_cs_o), 64'd1);
    checkOutput("midreset we", 64'(sram_we_o), 64'd1);
    checkOutput("midreset busy", 64'(busy_o), 64'd0);
    checkOutput("midreset address", 64'(sram_address_o), 64'd0);
    checkOutput("midreset words", 64'(words_written_o), 64'd0);
    checkOutput("midreset wait", 64'(sram_wait_o), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    writeQ.delete();
    busyQ.delete();
    modelAddr  = '0;
    modelCount = '0;

    // Normal operation resumes after reset.
    @(posedge clk); #1;
    applyStimulus($urandom, 1'b1);
    waitDone("post reset");
    endCheck("post reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
